// File: rtl/btb_update_sched_if.sv
// BTB update bus: ex mispredict strobe, sw write handshake
// and the registered BTB write port.
interface btb_update_sched_if #(
  parameter int unsigned VLEN = 64
) ();
  logic            ex_valid_i;
  logic [VLEN-1:0] ex_pc_i;
  logic [VLEN-1:0] ex_target_i;
  logic            sw_valid_i;
  logic            sw_ready_o;
  logic [VLEN-1:0] sw_pc_i;
  logic [VLEN-1:0] sw_target_i;
  logic            sw_set_valid_i;
  logic            upd_valid_o;
  logic [VLEN-1:0] upd_pc_o;
  logic [VLEN-1:0] upd_target_o;
  logic            upd_entry_valid_o;

  modport master (
    output ex_valid_i, ex_pc_i, ex_target_i,
    output sw_valid_i, sw_pc_i, sw_target_i,
    output sw_set_valid_i,
    input  sw_ready_o,
    input  upd_valid_o, upd_pc_o, upd_target_o,
    input  upd_entry_valid_o
  );

  modport slave (
    input  ex_valid_i, ex_pc_i, ex_target_i,
    input  sw_valid_i, sw_pc_i, sw_target_i,
    input  sw_set_valid_i,
    output sw_ready_o,
    output upd_valid_o, upd_pc_o, upd_target_o,
    output upd_entry_valid_o
  );
endinterface

// File: rtl/btb_update_sched.sv
// BTB write scheduler: mispredict FIFO, sw writes and a
// one-entry-per-cycle invalidation walk on one write port.
module btb_update_sched #(
  parameter int unsigned VLEN            = 64,
  parameter int unsigned NR_ENTRIES      = 8,
  parameter int unsigned INSTR_PER_FETCH = 2,
  parameter bit          RVC             = 1'b1,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        debug_mode_i,
  btb_update_sched_if.slave bus,
  output logic        walk_active_o,
  output logic        flush_done_o,
  output logic [15:0] drop_cnt_o
);
  localparam int unsigned OFFSET = RVC ? 1 : 2;
  localparam int unsigned IW =
    (NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned ROWS =
    NR_ENTRIES / INSTR_PER_FETCH;
  localparam logic [IW-1:0] LAST_IDX =
    IW'(ROWS * INSTR_PER_FETCH - 1);

  typedef enum logic {IDLE, WALK} state_e;

  typedef struct packed {
    logic [VLEN-1:0] pc;
    logic [VLEN-1:0] target;
  } upd_t;

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q;
  logic          rr_last_q;
  logic [AW:0]   wptr_q, rptr_q;
  upd_t          mem [FIFO_DEPTH];
  upd_t          head;

  logic arb_en, walk_wr, walk_last;
  logic empty, full;
  logic req_f, req_s, gnt_f, gnt_s;
  logic push_req, push, drop;

  assign head  = mem[rptr_q[AW-1:0]];
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                 (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (flush_i) state_d = WALK;
      WALK: begin
        if (flush_i)        state_d = WALK;
        else if (walk_last) state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    walk_active_o = 1'b0;
    arb_en        = 1'b0;
    walk_wr       = 1'b0;
    unique case (state_q)
      IDLE: arb_en = !flush_i && !debug_mode_i;
      WALK: begin
        walk_active_o = 1'b1;
        walk_wr       = !flush_i;
      end
    endcase
  end

  assign walk_last = walk_wr && (idx_q == LAST_IDX);

  // Contended grants go to whoever was not served last.
  assign req_f = !empty;
  assign req_s = bus.sw_valid_i;
  assign gnt_f = arb_en && req_f && (!req_s || rr_last_q);
  assign gnt_s = arb_en && req_s && (!req_f || !rr_last_q);
  assign bus.sw_ready_o = gnt_s;

  assign push_req = arb_en && bus.ex_valid_i;
  assign push     = push_req && (!full || gnt_f);
  assign drop     = push_req && full && !gnt_f;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push)  wptr_q <= wptr_q + 1'b1;
      if (gnt_f) rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push)
      mem[wptr_q[AW-1:0]] <= '{pc: bus.ex_pc_i,
                               target: bus.ex_target_i};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)              rr_last_q <= 1'b0;
    else if (gnt_f || gnt_s) rr_last_q <= gnt_s;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) idx_q <= '0;
    else if (walk_wr)
      idx_q <= walk_last ? '0 : idx_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bus.upd_valid_o       <= 1'b0;
      bus.upd_pc_o          <= '0;
      bus.upd_target_o      <= '0;
      bus.upd_entry_valid_o <= 1'b0;
    end else begin
      bus.upd_valid_o <= walk_wr || gnt_f || gnt_s;
      unique case (1'b1)
        walk_wr: begin
          bus.upd_pc_o          <= VLEN'(idx_q) << OFFSET;
          bus.upd_target_o      <= '0;
          bus.upd_entry_valid_o <= 1'b0;
        end
        gnt_f: begin
          bus.upd_pc_o          <= head.pc;
          bus.upd_target_o      <= head.target;
          bus.upd_entry_valid_o <= 1'b1;
        end
        gnt_s: begin
          bus.upd_pc_o          <= bus.sw_pc_i;
          bus.upd_target_o      <= bus.sw_target_i;
          bus.upd_entry_valid_o <= bus.sw_set_valid_i;
        end
        default: ;
      endcase
    end
  end

  // An aborted walk never reaches walk_last, so no stray pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) flush_done_o <= 1'b0;
    else       flush_done_o <= walk_last;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)
      drop_cnt_o <= '0;
    else if (drop && drop_cnt_o != 16'hFFFF)
      drop_cnt_o <= drop_cnt_o + 16'd1;
  end
endmodule

// File: tb/tb_btb_update_sched.sv
// Bench for btb_update_sched: vector table, walk, overflow,
// round-robin, debug and reset sequences against a write queue.
module tb_btb_update_sched;
  localparam int unsigned VLEN = 64;

  logic        clk;
  logic        rst_i;
  logic        flush_i;
  logic        debug_mode_i;
  logic        walk_active_o;
  logic        flush_done_o;
  logic [15:0] drop_cnt_o;

  btb_update_sched_if #(.VLEN(VLEN)) bus ();

  btb_update_sched #(
    .VLEN(VLEN), .NR_ENTRIES(8), .INSTR_PER_FETCH(2),
    .RVC(1'b1), .FIFO_DEPTH(4)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .debug_mode_i(debug_mode_i), .bus(bus),
    .walk_active_o(walk_active_o),
    .flush_done_o(flush_done_o), .drop_cnt_o(drop_cnt_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [63:0] pc;
    logic [63:0] tgt;
    logic        ev;
    int          cyc;
  } wr_t;

  typedef struct {
    bit          is_sw;
    logic [63:0] pc;
    logic [63:0] tgt;
    logic        sv;
    logic        exp_ev;
    int          lat;
  } vec_t;

  typedef struct {
    bit ex_v;
    int ex_id;
    bit sw_v;
    int sw_id;
    bit exp_rdy;
  } rr_t;

  wr_t exp_q[$];
  wr_t log_q[$];
  int  tests = 0;
  int  fails = 0;
  int  cyc = 0;
  bit  sb_en = 1'b1;
  int  done_cnt = 0;
  int  done_cyc = 0;
  int  act_cnt = 0;
  int  act_first = 0;
  int  rdy_cnt = 0;

  task automatic chk(input string name,
                     input logic [255:0] act,
                     input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    wr_t e;
    if (bus.upd_valid_o === 1'b1) begin
      if (sb_en) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected write: got pc %0h want none",
                   bus.upd_pc_o);
        end else begin
          e = exp_q.pop_front();
          chk("write {pc,tgt,ev,cyc}",
              {bus.upd_pc_o, bus.upd_target_o,
               bus.upd_entry_valid_o, cyc},
              {e.pc, e.tgt, e.ev, e.cyc});
        end
      end else begin
        log_q.push_back('{bus.upd_pc_o, bus.upd_target_o,
                          bus.upd_entry_valid_o, cyc});
      end
    end
    if (flush_done_o === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (walk_active_o === 1'b1) begin
      if (act_cnt == 0) act_first = cyc;
      act_cnt++;
    end
    if (bus.sw_valid_i && bus.sw_ready_o === 1'b1) rdy_cnt++;
  end

  vec_t vecs[5];
  rr_t  rrs[6];

  initial begin
    int base;
    int mism;
    int n;
    int exn;
    int swn;
    int last;
    logic [15:0] base_drop;

    vecs[0] = '{0, 64'h8000_0004, 64'h8000_0100, 0, 1, 2};
    vecs[1] = '{1, 64'h1234, 64'h5678, 1, 1, 1};
    vecs[2] = '{1, 64'h40, 64'h0, 0, 0, 1};
    vecs[3] = '{0, 64'hFFFF_FFFF_FFFF_FFFE, 64'h2, 0, 1, 2};
    vecs[4] = '{0, 64'h0, 64'hDEAD_BEEF, 0, 1, 2};

    rrs[0] = '{1, 0, 1, 0, 1};
    rrs[1] = '{1, 1, 1, 1, 0};
    rrs[2] = '{1, 2, 1, 1, 1};
    rrs[3] = '{0, 0, 1, 2, 0};
    rrs[4] = '{0, 0, 1, 2, 1};
    rrs[5] = '{0, 0, 0, 0, 0};

    rst_i = 1'b1;
    flush_i = 1'b0;
    debug_mode_i = 1'b0;
    bus.ex_valid_i = 1'b1;
    bus.ex_pc_i = 64'h8000_0004;
    bus.ex_target_i = 64'h8000_0100;
    bus.sw_valid_i = 1'b0;
    bus.sw_pc_i = '0;
    bus.sw_target_i = '0;
    bus.sw_set_valid_i = 1'b0;

    // reset with ex_valid held high
    step(2);
    chk("rst upd_valid", bus.upd_valid_o, 0);
    chk("rst upd_pc", bus.upd_pc_o, 0);
    chk("rst upd_target", bus.upd_target_o, 0);
    chk("rst upd_ev", bus.upd_entry_valid_o, 0);
    chk("rst walk_active", walk_active_o, 0);
    chk("rst flush_done", flush_done_o, 0);
    chk("rst drop_cnt", drop_cnt_o, 0);
    chk("rst sw_ready", bus.sw_ready_o, 0);
    rst_i = 1'b0;
    bus.ex_valid_i = 1'b0;
    step(4);
    chk("rst no push", exp_q.size(), 0);

    // single transactions
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back('{vecs[i].pc, vecs[i].tgt,
                        vecs[i].exp_ev, cyc + vecs[i].lat});
      if (vecs[i].is_sw) begin
        bus.sw_valid_i = 1'b1;
        bus.sw_pc_i = vecs[i].pc;
        bus.sw_target_i = vecs[i].tgt;
        bus.sw_set_valid_i = vecs[i].sv;
      end else begin
        bus.ex_valid_i = 1'b1;
        bus.ex_pc_i = vecs[i].pc;
        bus.ex_target_i = vecs[i].tgt;
      end
      #1;
      if (vecs[i].is_sw) chk("vec sw_ready", bus.sw_ready_o, 1);
      step(1);
      bus.sw_valid_i = 1'b0;
      bus.ex_valid_i = 1'b0;
      step(4);
    end
    chk("vec drain", exp_q.size(), 0);

    // full invalidation walk
    act_cnt = 0;
    done_cnt = 0;
    base = cyc;
    for (int k = 0; k < 8; k++)
      exp_q.push_back('{64'(2 * k), 64'd0, 1'b0, base + 2 + k});
    flush_i = 1'b1;
    step(1);
    flush_i = 1'b0;
    step(10);
    chk("walk active cycles", act_cnt, 8);
    chk("walk active first", act_first, base + 1);
    chk("walk done count", done_cnt, 1);
    chk("walk done cycle", done_cyc, base + 9);
    chk("walk drain", exp_q.size(), 0);

    // walk restarted at index 5
    sb_en = 1'b0;
    log_q.delete();
    done_cnt = 0;
    flush_i = 1'b1;
    step(1);
    flush_i = 1'b0;
    step(5);
    flush_i = 1'b1;
    step(1);
    flush_i = 1'b0;
    step(12);
    chk("abort done count", done_cnt, 1);
    n = log_q.size();
    chk("abort write count 13..14", (n >= 13 && n <= 14), 1);
    mism = 0;
    if (n >= 8) begin
      for (int k = 0; k < 8; k++) begin
        if (log_q[n - 8 + k].pc !== 64'(2 * k)) mism++;
        if (log_q[n - 8 + k].ev !== 1'b0) mism++;
      end
    end else begin
      mism = 99;
    end
    chk("abort restart sequence", mism, 0);

    // overflow while sw contends every other grant
    log_q.delete();
    rdy_cnt = 0;
    base_drop = drop_cnt_o;
    bus.sw_valid_i = 1'b1;
    bus.sw_pc_i = 64'hAAA0;
    bus.sw_target_i = 64'hBBB0;
    bus.sw_set_valid_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.ex_valid_i = 1'b1;
      bus.ex_pc_i = 64'h1000 + 64'(4 * i);
      bus.ex_target_i = 64'h2000 + 64'(i);
      step(1);
    end
    bus.ex_valid_i = 1'b0;
    bus.sw_valid_i = 1'b0;
    step(8);
    n = int'(drop_cnt_o - base_drop);
    chk("ovf drop 1..2", (n >= 1 && n <= 2), 1);
    exn = 0;
    swn = 0;
    last = -1;
    mism = 0;
    foreach (log_q[i]) begin
      if (log_q[i].pc == 64'hAAA0) begin
        swn++;
      end else begin
        exn++;
        if (int'(log_q[i].tgt - 64'h2000) <= last) mism++;
        last = int'(log_q[i].tgt - 64'h2000);
        if (log_q[i].pc !== 64'h1000 + 64'(4 * last)) mism++;
      end
    end
    chk("ovf ex writes + drops", exn + n, 10);
    chk("ovf ex order no dup", mism, 0);
    chk("ovf sw writes vs ready", swn, rdy_cnt);
    chk("ovf sw served", (rdy_cnt > 0), 1);

    // round-robin alternation
    sb_en = 1'b1;
    rdy_cnt = 0;
    base = cyc;
    exp_q.push_back('{64'h7000, 64'h7100, 1'b1, base + 1});
    exp_q.push_back('{64'h5000, 64'h6000, 1'b1, base + 2});
    exp_q.push_back('{64'h7004, 64'h7101, 1'b0, base + 3});
    exp_q.push_back('{64'h5004, 64'h6001, 1'b1, base + 4});
    exp_q.push_back('{64'h7008, 64'h7102, 1'b1, base + 5});
    exp_q.push_back('{64'h5008, 64'h6002, 1'b1, base + 6});
    for (int i = 0; i < 6; i++) begin
      bus.ex_valid_i = rrs[i].ex_v;
      bus.ex_pc_i = 64'h5000 + 64'(4 * rrs[i].ex_id);
      bus.ex_target_i = 64'h6000 + 64'(rrs[i].ex_id);
      bus.sw_valid_i = rrs[i].sw_v;
      bus.sw_pc_i = 64'h7000 + 64'(4 * rrs[i].sw_id);
      bus.sw_target_i = 64'h7100 + 64'(rrs[i].sw_id);
      bus.sw_set_valid_i = (rrs[i].sw_id != 1);
      #1;
      chk("rr sw_ready", bus.sw_ready_o, rrs[i].exp_rdy);
      step(1);
    end
    step(3);
    chk("rr ready pulses", rdy_cnt, 3);
    chk("rr drain", exp_q.size(), 0);

    // debug discards ex/sw and holds the FIFO
    base_drop = drop_cnt_o;
    rdy_cnt = 0;
    debug_mode_i = 1'b1;
    bus.ex_valid_i = 1'b1;
    bus.ex_pc_i = 64'h9000;
    bus.sw_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("dbg sw_ready", bus.sw_ready_o, 0);
      step(1);
    end
    bus.ex_valid_i = 1'b0;
    bus.sw_valid_i = 1'b0;
    debug_mode_i = 1'b0;
    step(3);
    chk("dbg drop unchanged", drop_cnt_o, base_drop);
    chk("dbg no ready", rdy_cnt, 0);
    exp_q.push_back('{64'h3000, 64'h3100, 1'b1, cyc + 5});
    bus.ex_valid_i = 1'b1;
    bus.ex_pc_i = 64'h3000;
    bus.ex_target_i = 64'h3100;
    step(1);
    bus.ex_valid_i = 1'b0;
    debug_mode_i = 1'b1;
    step(3);
    debug_mode_i = 1'b0;
    step(4);
    chk("dbg held entry drain", exp_q.size(), 0);

    // reset in the middle of a walk
    sb_en = 1'b0;
    log_q.delete();
    done_cnt = 0;
    flush_i = 1'b1;
    step(1);
    flush_i = 1'b0;
    step(3);
    rst_i = 1'b1;
    step(1);
    rst_i = 1'b0;
    chk("midrst walk_active", walk_active_o, 0);
    chk("midrst upd_valid", bus.upd_valid_o, 0);
    n = log_q.size();
    step(12);
    chk("midrst no done", done_cnt, 0);
    chk("midrst no writes", log_q.size(), n);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
